// File: rtl/radio_deserializer.sv
// Receive side of the radio 8-bit serial link: frame alignment, deserialization and
// I/Q sample unpacking, delivered through a valid/ready register with overflow accounting.
module radio_deserializer #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DIN_EN,
    input  logic             SYNC_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [1:0]       R0_I,
    output logic [1:0]       R0_Q,
    output logic [1:0]       R1_I,
    output logic [1:0]       R1_Q,
    output logic             LOCKED,
    output logic             OVERFLOW,
    output logic [CNT_W-1:0] FRAME_COUNT,
    output logic [CNT_W-1:0] OVF_COUNT
);

    localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GoodW-1:0] LockN   = GoodW'(LOCK_COUNT);
    localparam logic [MissW-1:0] UnlockN = MissW'(UNLOCK_COUNT);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [GoodW-1:0]   good_q, good_d, good_inc;
    logic [MissW-1:0]   miss_q, miss_d, miss_inc;
    logic               cmp_q, cmp_d;
    logic [7:0]         word_q, word_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q     <= StHunt;
            idx_q       <= '0;
            shreg_q     <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            cmp_q       <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            cmp_q       <= cmp_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // Alignment FSM and shift path; only qualified cycles advance anything here.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        good_d   = good_q;
        miss_d   = miss_q;
        cmp_d    = 1'b0;
        good_inc = good_q + GoodW'(1);
        miss_inc = miss_q + MissW'(1);
        if (DIN_EN) begin
            // LSB first: after eight shifts bit 0 of the frame sits in shreg[0].
            shreg_d = {DIN, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            case (state_q)
                StHunt: begin
                    if (SYNC_IN) begin
                        idx_d   = 3'd1;
                        good_d  = GoodW'(1);
                        miss_d  = '0;
                        state_d = (LOCK_COUNT == 1) ? StLocked : StVerify;
                    end else begin
                        idx_d = idx_q;
                    end
                end
                StVerify: begin
                    if (idx_q == 3'd0) begin
                        if (SYNC_IN) begin
                            good_d = good_inc;
                            if (good_inc == LockN) begin
                                state_d = StLocked;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = StHunt;
                        end
                    end else if (SYNC_IN) begin
                        // Strobe off the expected boundary: restart alignment on this bit.
                        idx_d  = 3'd1;
                        good_d = GoodW'(1);
                    end
                end
                StLocked: begin
                    if (idx_q == 3'd0) begin
                        if (SYNC_IN) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_inc;
                            if (miss_inc == UnlockN) begin
                                state_d = StHunt;
                            end
                        end
                    end
                    if (idx_q == 3'd7) begin
                        cmp_d = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // Output register: a completed word sits in shreg_q during the cycle cmp_q is high.
    always_comb begin
        word_d      = word_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        if (cmp_q) begin
            if (!valid_q || OUT_READY) begin
                word_d      = shreg_q;
                valid_d     = 1'b1;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != '1) begin
                    ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                end
            end
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        LOCKED                   = (state_q == StLocked);
        OUT_VALID                = valid_q;
        {R0_I, R0_Q, R1_I, R1_Q} = word_q;
        OVERFLOW                 = ovf_q;
        FRAME_COUNT              = frame_cnt_q;
        OVF_COUNT                = ovf_cnt_q;
    end

endmodule

// File: tb/tb_radio_deserializer.sv
// Randomized bench for radio_deserializer: expected words come from frame-level reasoning
// about when lock is held, compared against the words seen crossing the valid/ready handshake.
module tb_radio_deserializer;

    localparam int unsigned LOCK_N   = 4;
    localparam int unsigned UNLOCK_N = 2;
    localparam int unsigned CW       = 16;

    logic          SYS_CLK = 1'b0;
    logic          RST = 1'b1;
    logic          DIN = 1'b0;
    logic          DIN_EN = 1'b0;
    logic          SYNC_IN = 1'b0;
    logic          OUT_READY = 1'b0;
    logic          OUT_VALID;
    logic [1:0]    R0_I, R0_Q, R1_I, R1_Q;
    logic          LOCKED, OVERFLOW;
    logic [CW-1:0] FRAME_COUNT, OVF_COUNT;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    int         acc_t[$];

    radio_deserializer #(
        .LOCK_COUNT  (LOCK_N),
        .UNLOCK_COUNT(UNLOCK_N),
        .CNT_W       (CW)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_EN     (DIN_EN),
        .SYNC_IN    (SYNC_IN),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .R0_I       (R0_I),
        .R0_Q       (R0_Q),
        .R1_I       (R1_I),
        .R1_Q       (R1_Q),
        .LOCKED     (LOCKED),
        .OVERFLOW   (OVERFLOW),
        .FRAME_COUNT(FRAME_COUNT),
        .OVF_COUNT  (OVF_COUNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(posedge SYS_CLK) cyc <= cyc + 1;

    // Words actually handed to the consumer, with the cycle they crossed.
    always @(negedge SYS_CLK) begin
        if (!RST && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            acc_q.push_back({R0_I, R0_Q, R1_I, R1_Q});
            acc_t.push_back(cyc);
        end
    end

    task automatic drive_cycle(input logic en, input logic d, input logic s);
        DIN_EN  = en;
        DIN     = d;
        SYNC_IN = s;
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int first, input int last,
                             input bit sync_ok, input bit gap);
        for (int i = first; i <= last; i++) begin
            drive_cycle(1'b1, w[i], sync_ok && (i == 0));
            if (gap) idle(1);
        end
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        OUT_READY = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        acc_q.delete();
        acc_t.delete();
        exp_q.delete();
    endtask

    // LOCK_N aligned frames; only the last one is delivered.
    task automatic lock_up();
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < int'(LOCK_N); k++) begin
            w = 8'($urandom);
            send_bits(w, 0, 7, 1'b1, 1'b0);
        end
        exp_q.push_back(w);
        idle(3);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (OUT_VALID !== 1'b0) $display("FAIL rst_valid: got %b want 0", OUT_VALID); else passed++;
        checks++; if (LOCKED !== 1'b0) $display("FAIL rst_locked: got %b want 0", LOCKED); else passed++;
        checks++; if (OVERFLOW !== 1'b0) $display("FAIL rst_ovf: got %b want 0", OVERFLOW); else passed++;
        checks++; if (FRAME_COUNT !== '0) $display("FAIL rst_fcnt: got %0d want 0", FRAME_COUNT); else passed++;
        checks++; if (OVF_COUNT !== '0) $display("FAIL rst_ocnt: got %0d want 0", OVF_COUNT); else passed++;
        checks++; if ({R0_I, R0_Q, R1_I, R1_Q} !== 8'h00) $display("FAIL rst_word: got %h want 00", {R0_I, R0_Q, R1_I, R1_Q}); else passed++;
    endtask

    task automatic test_lock_acquire();
        logic [7:0] w;
        do_reset();
        OUT_READY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = 8'(k);
            send_bits(w, 0, 0, 1'b1, 1'b0);
            checks++;
            if (LOCKED !== (k >= int'(LOCK_N) - 1))
                $display("FAIL acq_locked_f%0d: got %b want %b", k, LOCKED, (k >= int'(LOCK_N) - 1));
            else passed++;
            send_bits(w, 1, 7, 1'b1, 1'b0);
            if (k >= int'(LOCK_N) - 1) exp_q.push_back(w);
        end
        idle(3);
        checks++; if (acc_q.size() != exp_q.size()) $display("FAIL acq_nwords: got %0d want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_q[i])
                $display("FAIL acq_word%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
        checks++; if (FRAME_COUNT !== CW'(7)) $display("FAIL acq_fcnt: got %0d want 7", FRAME_COUNT); else passed++;
        checks++; if (OVERFLOW !== 1'b0) $display("FAIL acq_ovf: got %b want 0", OVERFLOW); else passed++;
    endtask

    task automatic test_gapped();
        do_reset();
        OUT_READY = 1'b1;
        for (int k = 0; k < 10; k++) send_bits(8'hB4, 0, 7, 1'b1, 1'b1);
        idle(4);
        checks++; if (acc_q.size() != 7) $display("FAIL gap_nwords: got %0d want 7", acc_q.size()); else passed++;
        foreach (acc_q[i]) begin
            checks++;
            if (acc_q[i][7:6] !== 2'd2 || acc_q[i][5:4] !== 2'd3 || acc_q[i][3:2] !== 2'd1 ||
                acc_q[i][1:0] !== 2'd0)
                $display("FAIL gap_fields%0d: got %h want R0_I=2 R0_Q=3 R1_I=1 R1_Q=0", i, acc_q[i]);
            else passed++;
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++;
            if (acc_t[i] - acc_t[i-1] != 16)
                $display("FAIL gap_period%0d: got %0d cycles want 16", i, acc_t[i] - acc_t[i-1]);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        OUT_READY = 1'b1;
        lock_up();
        OUT_READY = 1'b0;
        send_bits(8'h11, 0, 7, 1'b1, 1'b0);
        send_bits(8'h22, 0, 7, 1'b1, 1'b0);
        checks++; if ({R0_I, R0_Q, R1_I, R1_Q} !== 8'h11) $display("FAIL ovf_hold_mid: got %h want 11", {R0_I, R0_Q, R1_I, R1_Q}); else passed++;
        send_bits(8'h33, 0, 7, 1'b1, 1'b0);
        idle(3);
        checks++; if (OUT_VALID !== 1'b1) $display("FAIL ovf_valid: got %b want 1", OUT_VALID); else passed++;
        checks++; if ({R0_I, R0_Q, R1_I, R1_Q} !== 8'h11) $display("FAIL ovf_hold: got %h want 11", {R0_I, R0_Q, R1_I, R1_Q}); else passed++;
        checks++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_flag: got %b want 1", OVERFLOW); else passed++;
        checks++; if (OVF_COUNT !== CW'(2)) $display("FAIL ovf_cnt: got %0d want 2", OVF_COUNT); else passed++;
        checks++; if (FRAME_COUNT !== CW'(2)) $display("FAIL ovf_fcnt: got %0d want 2", FRAME_COUNT); else passed++;
        OUT_READY = 1'b1;
        idle(1);
        OUT_READY = 1'b0;
        idle(1);
        exp_q.push_back(8'h11);
        checks++; if (OUT_VALID !== 1'b0) $display("FAIL ovf_drain: got %b want 0", OUT_VALID); else passed++;
        checks++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); else passed++;
        checks++; if (acc_q.size() != exp_q.size()) $display("FAIL ovf_nwords: got %0d want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_q[i])
                $display("FAIL ovf_word%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        do_reset();
        OUT_READY = 1'b1;
        lock_up();
        OUT_READY = 1'b0;
        send_bits(a, 0, 7, 1'b1, 1'b0);
        send_bits(b, 0, 7, 1'b1, 1'b0);
        // Ready only in the cycle the second word completes.
        OUT_READY = 1'b1;
        idle(1);
        OUT_READY = 1'b0;
        exp_q.push_back(a);
        checks++; if (OUT_VALID !== 1'b1) $display("FAIL b2b_valid: got %b want 1", OUT_VALID); else passed++;
        checks++; if ({R0_I, R0_Q, R1_I, R1_Q} !== b) $display("FAIL b2b_new: got %h want %h", {R0_I, R0_Q, R1_I, R1_Q}, b); else passed++;
        checks++; if (OVERFLOW !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", OVERFLOW); else passed++;
        checks++; if (OVF_COUNT !== '0) $display("FAIL b2b_ocnt: got %0d want 0", OVF_COUNT); else passed++;
        checks++; if (FRAME_COUNT !== CW'(3)) $display("FAIL b2b_fcnt: got %0d want 3", FRAME_COUNT); else passed++;
        OUT_READY = 1'b1;
        idle(2);
        exp_q.push_back(b);
        checks++; if (acc_q.size() != exp_q.size()) $display("FAIL b2b_nwords: got %0d want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_q[i])
                $display("FAIL b2b_word%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_unlock_relock();
        logic [7:0] w;
        do_reset();
        OUT_READY = 1'b1;
        lock_up();
        w = 8'($urandom);
        send_bits(w, 0, 0, 1'b0, 1'b0);
        checks++; if (LOCKED !== 1'b1) $display("FAIL unl_miss1: got %b want 1", LOCKED); else passed++;
        send_bits(w, 1, 7, 1'b0, 1'b0);
        exp_q.push_back(w);
        w = 8'($urandom);
        send_bits(w, 0, 0, 1'b0, 1'b0);
        checks++; if (LOCKED !== 1'b0) $display("FAIL unl_miss2: got %b want 0", LOCKED); else passed++;
        send_bits(w, 1, 7, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            send_bits(w, 0, 0, 1'b1, 1'b0);
            if (k == int'(LOCK_N) - 2) begin
                checks++; if (LOCKED !== 1'b0) $display("FAIL unl_early: got %b want 0", LOCKED); else passed++;
            end
            if (k == int'(LOCK_N) - 1) begin
                checks++; if (LOCKED !== 1'b1) $display("FAIL unl_relock: got %b want 1", LOCKED); else passed++;
            end
            send_bits(w, 1, 7, 1'b1, 1'b0);
            if (k >= int'(LOCK_N) - 1) exp_q.push_back(w);
        end
        idle(3);
        checks++; if (FRAME_COUNT !== CW'(5)) $display("FAIL unl_fcnt: got %0d want 5", FRAME_COUNT); else passed++;
        checks++; if (acc_q.size() != exp_q.size()) $display("FAIL unl_nwords: got %0d want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_q[i])
                $display("FAIL unl_word%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_realign();
        logic [7:0] w;
        do_reset();
        OUT_READY = 1'b1;
        w = 8'($urandom);
        send_bits(w, 0, 4, 1'b1, 1'b0);
        // The next strobe lands at bit index 5 and defines the new alignment.
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            send_bits(w, 0, 0, 1'b1, 1'b0);
            if (k == int'(LOCK_N) - 2) begin
                checks++; if (LOCKED !== 1'b0) $display("FAIL rea_early: got %b want 0", LOCKED); else passed++;
            end
            if (k == int'(LOCK_N) - 1) begin
                checks++; if (LOCKED !== 1'b1) $display("FAIL rea_lock: got %b want 1", LOCKED); else passed++;
            end
            send_bits(w, 1, 7, 1'b1, 1'b0);
            if (k >= int'(LOCK_N) - 1) exp_q.push_back(w);
        end
        idle(3);
        checks++; if (acc_q.size() != exp_q.size()) $display("FAIL rea_nwords: got %0d want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            checks++;
            if (i >= acc_q.size() || acc_q[i] !== exp_q[i])
                $display("FAIL rea_word%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        do_reset();
        lock_up();
        checks++; if (OUT_VALID !== 1'b1) $display("FAIL mrst_pre_valid: got %b want 1", OUT_VALID); else passed++;
        send_bits(8'($urandom), 0, 3, 1'b1, 1'b0);
        RST = 1'b1;
        drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        RST = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) $display("FAIL mrst_valid: got %b want 0", OUT_VALID); else passed++;
        checks++; if (LOCKED !== 1'b0) $display("FAIL mrst_locked: got %b want 0", LOCKED); else passed++;
        checks++; if (FRAME_COUNT !== '0) $display("FAIL mrst_fcnt: got %0d want 0", FRAME_COUNT); else passed++;
        checks++; if (OVF_COUNT !== '0 || OVERFLOW !== 1'b0) $display("FAIL mrst_ovf: got %0d/%b want 0/0", OVF_COUNT, OVERFLOW); else passed++;
        checks++; if ({R0_I, R0_Q, R1_I, R1_Q} !== 8'h00) $display("FAIL mrst_word: got %h want 00", {R0_I, R0_Q, R1_I, R1_Q}); else passed++;
        acc_q.delete();
        exp_q.delete();
        OUT_READY = 1'b1;
        for (int k = 0; k < int'(LOCK_N); k++) begin
            w = 8'($urandom);
            send_bits(w, 0, 0, 1'b1, 1'b0);
            checks++;
            if (LOCKED !== (k == int'(LOCK_N) - 1))
                $display("FAIL mrst_relock_f%0d: got %b want %b", k, LOCKED, (k == int'(LOCK_N) - 1));
            else passed++;
            send_bits(w, 1, 7, 1'b1, 1'b0);
        end
        exp_q.push_back(w);
        idle(3);
        checks++; if (acc_q.size() != 1 || acc_q[0] !== exp_q[0]) $display("FAIL mrst_word_after: got %0d words first %h want 1 word %h", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 8'hxx, exp_q[0]); else passed++;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_gapped();
        test_overflow();
        test_back_to_back();
        test_unlock_relock();
        test_realign();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/radio_deserializer.md
Name: radio_deserializer

Overview:
- Receive-side counterpart of the radio module's 8-bit serial data link.
- Recovers frame alignment from a serial data bit plus a frame-sync strobe, deserializes each 8-bit frame and unpacks it into the two radios' 2-bit I/Q samples.
- Delivers samples over a valid/ready interface with overflow accounting.
- Sits in the correlator/capture FPGA directly behind the link input pins; inputs arrive already synchronised to SYS_CLK.

Parameters:
- LOCK_COUNT, 4, consecutive correctly placed sync strobes needed to declare lock (>=1).
- UNLOCK_COUNT, 2, consecutive missing sync strobes at the frame boundary that drop lock (>=1).
- CNT_W, 16, width of the frame and overflow counters.

Ports:
- SYS_CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- DIN  in  1  serial data bit.
- DIN_EN  in  1  qualifies DIN/SYNC_IN; one link bit per cycle where high.
- SYNC_IN  in  1  frame strobe; high on the qualified cycle carrying bit 0.
- OUT_VALID  out  1  output word valid.
- OUT_READY  in  1  consumer accepts word when OUT_VALID & OUT_READY.
- R0_I, R0_Q, R1_I, R1_Q  out  2 each  unpacked samples of the held word.
- LOCKED  out  1  high in LOCKED state.
- OVERFLOW  out  1  sticky; set on a dropped word; cleared only by RST.
- FRAME_COUNT  out  CNT_W  words delivered into the output register; wraps.
- OVF_COUNT  out  CNT_W  words dropped; saturates at all-ones.

Behaviour:
- Frame format: bits arrive LSB first. Bit 0 is first, with SYNC_IN. Word[7:0] = {R0_I, R0_Q, R1_I, R1_Q}, so R1_Q[0] is sent first and R0_I[1] last.
- Non-qualified cycles (DIN_EN=0) change no state except the output handshake.
- Internal registers: 3-bit bit index, 8-bit shift register, good counter, miss counter, state HUNT/VERIFY/LOCKED.
- Reset: state HUNT; all outputs and counters 0; OUT_VALID=0; LOCKED=0.
- HUNT:
  - Qualified SYNC_IN=1: store DIN as bit 0, index=1, good=1.
  - Go to LOCKED if LOCK_COUNT=1, else to VERIFY.
- VERIFY:
  - Shift each qualified bit in.
  - Index 0 (expected boundary) with SYNC_IN=1: good+1. If good reaches LOCK_COUNT, go to LOCKED, miss=0.
  - Index 0 with SYNC_IN=0: go to HUNT.
  - SYNC_IN=1 at index!=0: realign. Treat that bit as bit 0, index=1, good=1, stay in VERIFY.
  - No words are delivered in VERIFY.
- LOCKED:
  - Index 0 with SYNC_IN=1: miss=0.
  - Index 0 with SYNC_IN=0: miss+1. Reaching UNLOCK_COUNT goes to HUNT and discards the frame in progress.
  - SYNC_IN at index!=0 is ignored.
  - Index wraps 7->0.
  - When bit 7 is sampled on cycle t, the completed word is offered to the output register at t+1. This is the word completion event.
- Output register:
  - On completion, if OUT_VALID=0 or OUT_READY=1 that cycle: load word, OUT_VALID=1 at t+1, FRAME_COUNT+1.
  - Otherwise: keep the held word unchanged, set OVERFLOW, OVF_COUNT+1 (saturating).
  - Handshake without completion: OUT_VALID falls the cycle after acceptance.
  - Held data stays stable while OUT_VALID=1 and not accepted.
- Loss of lock does not clear a held word; it still drains by handshake.
- RST mid-frame or mid-handshake: everything returns to reset values next cycle; the held word is lost.
- Throughput: one word per 8 qualified cycles. Continuous DIN_EN=1 with OUT_READY=1 gives no overflow.

Test Plan:
- Reset, then 10 frames of continuous DIN_EN=1, correct SYNC_IN, words 0x00..0x09, OUT_READY=1 -> LOCKED rises after bit 0 of the 4th frame (frame 0x03). First delivered word is 0x03 (R0_I=0, R1_Q=3). FRAME_COUNT=7. OVERFLOW=0.
- Locked stream of word 0xB4, DIN_EN toggling 1,0 -> identical words. R0_I=2, R0_Q=3, R1_I=1, R1_Q=0. One OUT_VALID per 16 cycles.
- Locked, OUT_READY=0 for 3 frames (0x11, 0x22, 0x33) -> held word stays 0x11. OVERFLOW=1. OVF_COUNT=2.
- OUT_READY=1 on the same cycle a new word completes -> old word accepted, new word loaded. No overflow.
- Locked, SYNC_IN removed for 2 consecutive boundaries -> LOCKED=0 after the 2nd missing boundary. Re-asserting sync relocks after 4 good strobes.
- VERIFY with SYNC_IN pulse at bit index 5 -> realignment to that bit. Subsequent words are decoded with the new alignment after relock.
- Assert RST mid-frame while OUT_VALID=1 -> all outputs and counters 0 next cycle. Relock needs 4 strobes.
